dm_lsu: RTL and testbench

DM_LSU -- requirements
Module: dm_lsu

---
 rtl/dm_lsu.sv | 184 ++++++++++++++++++
 tb/tb_dm_lsu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// Single-port data-memory load/store unit: byte/half/word and unaligned-merge (LWL/LWR/SWL/SWR)
// accesses on a word-organised RAM, with a post-reset zero sweep and one request in flight.
module dm_lsu #(
    parameter int DEPTH_LOG2 = 11,
    parameter int RD_LAT     = 1,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy_init
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [3:0] OP_LW  = 4'd0,  OP_LH  = 4'd1,  OP_LHU = 4'd2,  OP_LB  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4,  OP_LWL = 4'd5,  OP_LWR = 4'd6,  OP_SW  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9,  OP_SB  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;
    localparam state_t RESET_STATE = INIT_CLEAR ? INIT : IDLE;

    logic [31:0] mem [DEPTH];

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2-1:0] sweep_reg, sweep_next;
    logic [1:0]            wait_reg, wait_next;
    logic [3:0]            op_reg;
    logic [1:0]            lane_reg;
    logic [31:0]           old_reg;
    logic                  err_reg;
    logic [31:0]           rd_reg;

    logic [1:0]            lane;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  accept, req_err, is_store;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic [31:0]           shifted, keep_l, keep_r, load_data;
    logic [15:0]           half;
    logic                  unused_addr;

    assign lane        = req_addr[1:0];
    assign word_idx    = req_addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];
    assign req_ready   = (state_reg == IDLE);
    assign accept      = req_valid && req_ready;
    assign is_store    = req_op[3];

    always_comb begin
        req_err = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         req_err = (lane != 2'd0);
            OP_LH, OP_LHU, OP_SH: req_err = lane[0];
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB, OP_SWL, OP_SWR: req_err = 1'b0;
            default:              req_err = 1'b1;
        endcase
    end

    // Stores are pre-aligned to their byte lanes so one masked word write covers every op.
    always_comb begin
        st_be   = 4'h0;
        st_data = 32'h0;
        case (req_op)
            OP_SW:  begin st_be = 4'hF;                             st_data = req_wdata; end
            OP_SH:  begin st_be = lane[1] ? 4'b1100 : 4'b0011;      st_data = {2{req_wdata[15:0]}}; end
            OP_SB:  begin st_be = 4'b0001 << lane;                  st_data = {4{req_wdata[7:0]}}; end
            OP_SWL: begin st_be = 4'b1111 >> (~lane);               st_data = req_wdata >> {~lane, 3'b000}; end
            OP_SWR: begin st_be = 4'b1111 << lane;                  st_data = req_wdata << {lane, 3'b000}; end
            default: ;
        endcase
    end

    assign wr_en   = (state_reg == INIT) || (accept && is_store && !req_err);
    assign wr_idx  = (state_reg == INIT) ? sweep_reg : word_idx;
    assign wr_be   = (state_reg == INIT) ? 4'hF : st_be;
    assign wr_data = (state_reg == INIT) ? 32'h0 : st_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (accept) rd_reg <= mem[word_idx];
    end

    assign shifted = rd_reg >> {lane_reg, 3'b000};
    assign half    = lane_reg[1] ? rd_reg[31:16] : rd_reg[15:0];

    // Bytes of the old register value that survive an LWL/LWR merge.
    always_comb begin
        keep_l = 32'h0;
        keep_r = 32'h0;
        case (lane_reg)
            2'd0: begin keep_l = 32'h00FF_FFFF; keep_r = 32'h0000_0000; end
            2'd1: begin keep_l = 32'h0000_FFFF; keep_r = 32'hFF00_0000; end
            2'd2: begin keep_l = 32'h0000_00FF; keep_r = 32'hFFFF_0000; end
            default: begin keep_l = 32'h0000_0000; keep_r = 32'hFFFF_FF00; end
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (op_reg)
            OP_LW:  load_data = rd_reg;
            OP_LH:  load_data = {{16{half[15]}}, half};
            OP_LHU: load_data = {16'h0, half};
            OP_LB:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU: load_data = {24'h0, shifted[7:0]};
            OP_LWL: load_data = (rd_reg << {~lane_reg, 3'b000}) | (old_reg & keep_l);
            OP_LWR: load_data = (rd_reg >> {lane_reg, 3'b000}) | (old_reg & keep_r);
            default: ;
        endcase
    end

    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign rsp_rdata = ((state_reg == RESP) && !err_reg) ? load_data : 32'h0;
    assign busy_init = (state_reg == INIT);

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        wait_next  = wait_reg;
        case (state_reg)
            INIT: begin
                sweep_next = sweep_reg + 1'b1;
                if (&sweep_reg) state_next = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    if (!req_err && !is_store && (RD_LAT > 1)) begin
                        state_next = WAIT;
                        wait_next  = 2'(RD_LAT - 2);
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_reg == 2'd0) state_next = RESP;
                else                  wait_next  = wait_reg - 1'b1;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RESET_STATE;
            sweep_reg <= '0;
            wait_reg  <= 2'd0;
            op_reg    <= 4'd0;
            lane_reg  <= 2'd0;
            old_reg   <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            wait_reg  <= wait_next;
            if (accept) begin
                op_reg   <= req_op;
                lane_reg <= lane;
                old_reg  <= req_wdata;
                err_reg  <= req_err;
            end
        end
    end
endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: default instance (2048 words, RD_LAT=1) plus a small RD_LAT=3 instance.
module tb_dm_lsu;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy_init;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        reset3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3, busy_init3;
    logic [3:0]  req_op3;
    logic [31:0] req_addr3, req_wdata3, rsp_rdata3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm_lsu dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy_init(busy_init)
    );

    dm_lsu #(.DEPTH_LOG2(4), .RD_LAT(3), .INIT_CLEAR(1'b1)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op3), .req_addr(req_addr3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
        .rsp_err(rsp_err3), .busy_init(busy_init3)
    );

    task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL xact_ready_timeout op=%0d req_ready got 0 want 1", op);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 4'd7; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_5A5A;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        $display("xact op=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d", op, addr, wd, rd, er, lat);
        rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic xact3(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        @(negedge clk);
        req_valid3 = 1'b1; req_op3 = op; req_addr3 = addr; req_wdata3 = wd;
        while (!req_ready3 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL xact3_ready_timeout op=%0d req_ready got 0 want 1", op);
        end
        @(posedge clk); #1;
        req_valid3 = 1'b0; req_op3 = 4'd7; req_addr3 = 32'hFFFF_FFFF; req_wdata3 = 32'hA5A5_5A5A;
        lat = 1;
        while (!rsp_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata3; er = rsp_err3;
        $display("xact3 op=%0d addr=%h wdata=%h -> rdata=%h err=%b lat=%0d", op, addr, wd, rd, er, lat);
        rsp_ready3 = 1'b1; @(posedge clk); #1; rsp_ready3 = 1'b0;
    endtask

    task automatic test_reset();
        int cyc = 0;
        int bad = 0;
        logic [31:0] rd;
        logic er;
        int lat;
        repeat (3) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        n_cmp++; if (busy_init !== 1'b1) begin n_fail++; $display("FAIL reset_busy_init got %b want 1", busy_init); end
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h0000_1FFC; req_wdata = 32'h0;
        reset = 1'b1; reset3 = 1'b1;
        while (busy_init && cyc < 3000) begin
            if (req_ready) bad++;
            cyc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        $display("sweep busy_init cycles=%0d ready_during_sweep=%0d", cyc, bad);
        n_cmp++; if (cyc != 2048) begin n_fail++; $display("FAIL sweep_cycles got %0d want 2048", cyc); end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL sweep_ready_early got %0d want 0", bad); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready_after got %b want 1", req_ready); end
        xact(4'd0, 32'h0000_1FFC, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_top_word rdata got %h want 00000000", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_top_word err got %b want 0", er); end
    endtask

    task automatic test_store_load();
        logic [3:0]  ops [13] = '{4'd8, 4'd3, 4'd4, 4'd1, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd10, 4'd9, 4'd0, 4'd3};
        logic [31:0] adr [13] = '{32'h10, 32'h13, 32'h10, 32'h12, 32'h10, 32'h10, 32'h12, 32'h11, 32'h13,
                                  32'h11, 32'h12, 32'h10, 32'h12};
        logic [31:0] wd  [13] = '{32'h1122_3344, 32'h0, 32'h0, 32'h0, 32'h80FF_8000, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0000_00AB, 32'h0000_CAFE, 32'h0, 32'h0};
        logic [31:0] exp [13] = '{32'h0, 32'h0000_0011, 32'h0000_0044, 32'h0000_1122, 32'h0, 32'hFFFF_8000,
                                  32'h0000_80FF, 32'hFFFF_FF80, 32'h0000_0080, 32'h0, 32'h0, 32'hCAFE_AB00,
                                  32'hFFFF_FFFE};
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 13; i++) begin
            xact(ops[i], adr[i], wd[i], rd, er, lat);
            n_cmp++; if (rd !== exp[i]) begin n_fail++; $display("FAIL store_load[%0d] rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL store_load[%0d] err got %b want 0", i, er); end
            n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL store_load[%0d] latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_merge();
        logic [3:0]  ops [14] = '{4'd8, 4'd5, 4'd6, 4'd5, 4'd5, 4'd6, 4'd11, 4'd0, 4'd12, 4'd0, 4'd11, 4'd0, 4'd12, 4'd0};
        logic [31:0] adr [14] = '{32'h20, 32'h21, 32'h21, 32'h23, 32'h20, 32'h23, 32'h20, 32'h20, 32'h23, 32'h20,
                                  32'h22, 32'h20, 32'h21, 32'h20};
        logic [31:0] wd  [14] = '{32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344, 32'h1122_3344, 32'h1122_3344,
                                  32'h1122_3344, 32'h5566_7788, 32'h0, 32'h5566_7788, 32'h0, 32'h5566_7788,
                                  32'h0, 32'h5566_7788, 32'h0};
        logic [31:0] exp [14] = '{32'h0, 32'hCCDD_3344, 32'h11AA_BBCC, 32'hAABB_CCDD, 32'hDD22_3344,
                                  32'h1122_33AA, 32'h0, 32'hAABB_CC55, 32'h0, 32'h88BB_CC55, 32'h0,
                                  32'h8855_6677, 32'h0, 32'h6677_8877};
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 14; i++) begin
            xact(ops[i], adr[i], wd[i], rd, er, lat);
            n_cmp++; if (rd !== exp[i]) begin n_fail++; $display("FAIL merge[%0d] rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL merge[%0d] err got %b want 0", i, er); end
        end
    endtask

    task automatic test_errors();
        logic [3:0]  ops [10] = '{4'd8, 4'd0, 4'd9, 4'd0, 4'd8, 4'd1, 4'd7, 4'd15, 4'd13, 4'd0};
        logic [31:0] adr [10] = '{32'h04, 32'h02, 32'h05, 32'h04, 32'h06, 32'h07, 32'h04, 32'h04, 32'h04, 32'h04};
        logic [31:0] wd  [10] = '{32'h1234_5678, 32'h0, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] exp [10] = '{32'h0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h1234_5678};
        logic        eer [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 10; i++) begin
            xact(ops[i], adr[i], wd[i], rd, er, lat);
            n_cmp++; if (rd !== exp[i]) begin n_fail++; $display("FAIL errors[%0d] rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (er !== eer[i]) begin n_fail++; $display("FAIL errors[%0d] err got %b want %b", i, er, eer[i]); end
            n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL errors[%0d] latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_alias();
        logic [3:0]  ops [3] = '{4'd8, 4'd0, 4'd0};
        logic [31:0] adr [3] = '{32'h0000_2010, 32'h0000_0010, 32'hFFFF_E010};
        logic [31:0] exp [3] = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 3; i++) begin
            xact(ops[i], adr[i], 32'hDEAD_BEEF, rd, er, lat);
            n_cmp++; if (rd !== exp[i]) begin n_fail++; $display("FAIL alias[%0d] rdata got %h want %h", i, rd, exp[i]); end
            n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL alias[%0d] err got %b want 0", i, er); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic er;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd8; req_addr = 32'h30; req_wdata = 32'h0000_0001;
        @(posedge clk); #1;
        $display("b2b first response: rsp_valid=%b req_ready=%b", rsp_valid, req_ready);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %b want 1", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_resp got %b want 0", req_ready); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume_no_accept rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %b want 1", rsp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_consumed got %b want 0", rsp_valid); end
        xact(4'd0, 32'h30, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_readback got %h want 00000001", rd); end
    endtask

    task automatic test_rd_lat3();
        logic [31:0] rd;
        logic er;
        int lat;
        int n = 0;
        int bad = 0;
        while (busy_init3 && n < 100) begin @(negedge clk); n++; end
        n_cmp++; if (busy_init3 !== 1'b0) begin n_fail++; $display("FAIL lat3_sweep busy_init got %b want 0", busy_init3); end
        xact3(4'd8, 32'h08, 32'hCAFE_F00D, rd, er, lat);
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL lat3_store latency got %0d want 1", lat); end
        @(negedge clk);
        req_valid3 = 1'b1; req_op3 = 4'd0; req_addr3 = 32'h08; req_wdata3 = 32'h0;
        n_cmp++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL lat3_ready got %b want 1", req_ready3); end
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        lat = 1;
        while (!rsp_valid3 && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lat3_load latency got %0d want 3", lat); end
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid3 !== 1'b1 || rsp_rdata3 !== 32'hCAFE_F00D || req_ready3 !== 1'b0) bad++;
        end
        $display("lat3 hold: lat=%0d rdata=%h unstable_cycles=%0d", lat, rsp_rdata3, bad);
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL lat3_hold unstable cycles got %0d want 0", bad); end
        rsp_ready3 = 1'b1; @(posedge clk); #1; rsp_ready3 = 1'b0;
        n_cmp++; if (rsp_valid3 !== 1'b0) begin n_fail++; $display("FAIL lat3_release rsp_valid got %b want 0", rsp_valid3); end
        n_cmp++; if (req_ready3 !== 1'b1) begin n_fail++; $display("FAIL lat3_release req_ready got %b want 1", req_ready3); end
        xact3(4'd0, 32'h48, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lat3_alias rdata got %h want cafef00d", rd); end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lat3_alias latency got %0d want 3", lat); end
        xact3(4'd3, 32'h0B, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFF_FFCA) begin n_fail++; $display("FAIL lat3_lb rdata got %h want ffffffca", rd); end
        xact3(4'd1, 32'h09, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL lat3_err err got %b want 1", er); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL lat3_err latency got %0d want 1", lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        int cyc = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mid_pre_rdata got %h want deadbeef", rsp_rdata); end
        #2;
        reset = 1'b0;
        #1;
        $display("mid-reset: rsp_valid=%b rsp_rdata=%h busy_init=%b", rsp_valid, rsp_rdata, busy_init);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_rsp_rdata got %h want 0", rsp_rdata); end
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_req_ready got %b want 0", req_ready); end
        n_cmp++; if (busy_init !== 1'b1) begin n_fail++; $display("FAIL mid_busy_init got %b want 1", busy_init); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        while (busy_init && cyc < 3000) begin cyc++; @(negedge clk); end
        n_cmp++; if (cyc != 2048) begin n_fail++; $display("FAIL mid_sweep_cycles got %0d want 2048", cyc); end
        xact(4'd0, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_cleared rdata got %h want 00000000", rd); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        reset3 = 1'b0; req_valid3 = 1'b0; req_op3 = 4'd0; req_addr3 = 32'h0; req_wdata3 = 32'h0; rsp_ready3 = 1'b0;
        test_reset();
        test_store_load();
        test_merge();
        test_errors();
        test_alias();
        test_back_to_back();
        test_rd_lat3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
